// File: rtl/reaction_pkg.sv
// -----------------------------------------------------------------------------
// reaction_pkg
// Shared constants and types for the reaction timer: LFSR seed and tap
// positions, score ceiling, delay-FSM state encoding, and a width helper used
// to size counters from parameters.
// No ports (package).
// -----------------------------------------------------------------------------
package reaction_pkg;

   // Non-zero seed; the LFSR is maximal-length, so it never reaches zero.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Taps in the usual 1..16 numbering. The register shifts toward bit 0,
   // so tap n sits at register bit 16-n.
   localparam int LFSR_TAP_A = 16;
   localparam int LFSR_TAP_B = 14;
   localparam int LFSR_TAP_C = 13;
   localparam int LFSR_TAP_D = 11;

   localparam int                 SCORE_W   = 13;
   localparam logic [SCORE_W-1:0] SCORE_MAX = 13'd8191;

   typedef enum logic [1:0] {
      D_IDLE  = 2'd0,
      D_COUNT = 2'd1,
      D_DONE  = 2'd2
   } delayState_t;

   // Number of bits needed to hold maxValue (at least 1).
   function automatic int bitsFor(input int maxValue);
      int width;
      width = 1;
      for (int w = 1; w < 31; w++) begin
         if ((1 << w) <= maxValue) width = w + 1;
      end
      return width;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing every
// clock. Supplies the random part of the red-phase delay.
// Ports:
//   Clock      in   rising-edge clock
//   CLRN       in   asynchronous active-low reset (loads LFSR_SEED)
//   lfsrValue  out  current register contents
// -----------------------------------------------------------------------------
module lfsr16
   import reaction_pkg::*;
(
   input  logic        Clock,
   input  logic        CLRN,
   output logic [15:0] lfsrValue
);

   logic feedback;

   assign feedback = lfsrValue[16-LFSR_TAP_A] ^ lfsrValue[16-LFSR_TAP_B] ^
                     lfsrValue[16-LFSR_TAP_C] ^ lfsrValue[16-LFSR_TAP_D];

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge Clock or negedge CLRN) begin
      if (!CLRN) begin
         lfsrValue <= LFSR_SEED;
      end else if (lfsrValue == '0) begin
         // All-zero is the one lockup state; recover rather than stick.
         lfsrValue <= LFSR_SEED;
      end else begin
         lfsrValue <= {feedback, lfsrValue[15:1]};
      end
   end

endmodule

// File: rtl/reaction_timer.sv
// -----------------------------------------------------------------------------
// reaction_timer
// Timing core of a reaction-time game. A random red-phase delay
// (MIN_DELAY_MS + LFSR low bits, in ms) is counted down while
// delayCounterEnable is high; then a millisecond score counter runs while
// scoreCounterEnable is high. Both counters share one ms prescaler.
// Parameters:
//   CLK_HZ        clock frequency; one ms tick every CLK_HZ/1000 clocks
//   MIN_DELAY_MS  fixed part of the red-phase delay
//   RAND_BITS     width of the random delay addend
// Ports:
//   Clock               in   rising-edge clock
//   CLRN                in   asynchronous active-low reset
//   delayCounterEnable  in   high during the red/waiting phase
//   scoreCounterEnable  in   high during the green/measuring phase
//   delayCounterDone    out  delay expired; held until the next delay load
//   scoreCounter        out  elapsed reaction time in ms (13 bits)
//   scoreSaturated      out  scoreCounter has reached 8191
// -----------------------------------------------------------------------------
module reaction_timer
   import reaction_pkg::*;
#(
   parameter int CLK_HZ       = 50000000,
   parameter int MIN_DELAY_MS = 1000,
   parameter int RAND_BITS    = 11
) (
   input  logic        Clock,
   input  logic        CLRN,
   input  logic        delayCounterEnable,
   input  logic        scoreCounterEnable,
   output logic        delayCounterDone,
   output logic [12:0] scoreCounter,
   output logic        scoreSaturated
);

   localparam int TICK_CLOCKS = CLK_HZ / 1000;
   localparam int PRESC_W     = bitsFor(TICK_CLOCKS - 1);
   localparam int DELAY_W     = bitsFor(MIN_DELAY_MS + (1 << RAND_BITS) - 1);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CLOCKS - 1);

   logic [15:0]        lfsrValue;
   logic               unusedLfsrBits;
   logic               delayEnPrev;
   logic               scoreEnPrev;
   logic               delayRise;
   logic               scoreRise;
   logic [PRESC_W-1:0] prescaler;
   logic               msTick;
   logic [DELAY_W-1:0] delayCount;
   logic [DELAY_W-1:0] delayLoad;
   delayState_t        delayState;
   logic [12:0]        scoreNext;

   lfsr16 lfsrInst (
      .Clock     (Clock),
      .CLRN      (CLRN),
      .lfsrValue (lfsrValue)
   );

   // Only the low RAND_BITS bits feed the delay; the upper bits are spare.
   assign unusedLfsrBits = ^lfsrValue;

   assign delayLoad = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsrValue[RAND_BITS-1:0]);

   // ---------------------------------------------------------------------------
   // Input edge detection
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clock or negedge CLRN) begin
      if (!CLRN) begin
         delayEnPrev <= 1'b0;
         scoreEnPrev <= 1'b0;
      end else begin
         delayEnPrev <= delayCounterEnable;
         scoreEnPrev <= scoreCounterEnable;
      end
   end

   assign delayRise = delayCounterEnable & ~delayEnPrev;
   assign scoreRise = scoreCounterEnable & ~scoreEnPrev;

   // ---------------------------------------------------------------------------
   // Shared ms prescaler. Either phase starting re-phases it so that phase's
   // first tick lands a full ms after its start.
   // ---------------------------------------------------------------------------
   assign msTick = (prescaler == PRESC_LAST);

   always_ff @(posedge Clock or negedge CLRN) begin
      if (!CLRN) begin
         prescaler <= '0;
      end else if (delayRise || scoreRise || msTick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + PRESC_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Delay FSM with registered done flag
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clock or negedge CLRN) begin
      if (!CLRN) begin
         delayState       <= D_IDLE;
         delayCount       <= '0;
         delayCounterDone <= 1'b0;
      end else begin
         case (delayState)
            D_IDLE: begin
               if (delayRise) begin
                  delayCount <= delayLoad;
                  delayState <= D_COUNT;
               end
            end
            D_COUNT: begin
               // Abort wins over a tick landing on the same clock.
               if (!delayCounterEnable) begin
                  delayCount <= '0;
                  delayState <= D_IDLE;
               end else if (msTick) begin
                  // <= 1 also covers a zero load (MIN_DELAY_MS of 0).
                  if (delayCount <= DELAY_W'(1)) begin
                     delayCount       <= '0;
                     delayState       <= D_DONE;
                     delayCounterDone <= 1'b1;
                  end else begin
                     delayCount <= delayCount - DELAY_W'(1);
                  end
               end
            end
            D_DONE: begin
               if (delayRise) begin
                  delayCount       <= delayLoad;
                  delayState       <= D_COUNT;
                  delayCounterDone <= 1'b0;
               end
            end
            default: begin
               delayCount       <= '0;
               delayState       <= D_IDLE;
               delayCounterDone <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Score counter: clear while red, count ms while green, saturate at max.
   // The increment is suppressed on the start clock so the first count lands
   // exactly one ms after scoreCounterEnable rises.
   // ---------------------------------------------------------------------------
   // NOTE: scoreNext is given a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      scoreNext = scoreCounter;
      if (delayCounterEnable) begin
         scoreNext = '0;
      end else if (scoreCounterEnable && msTick && !scoreRise &&
                   (scoreCounter != SCORE_MAX)) begin
         scoreNext = scoreCounter + 13'd1;
      end
   end

   always_ff @(posedge Clock or negedge CLRN) begin
      if (!CLRN) begin
         scoreCounter   <= '0;
         scoreSaturated <= 1'b0;
      end else begin
         scoreCounter   <= scoreNext;
         scoreSaturated <= (scoreNext == SCORE_MAX);
      end
   end

endmodule

// File: tb/tb_reaction_timer.sv
// -----------------------------------------------------------------------------
// tb_reaction_timer
// Self-checking bench for reaction_timer at CLK_HZ=4000 (4-clock ms tick),
// MIN_DELAY_MS=2, RAND_BITS=2. Inputs are driven and outputs sampled on the
// falling clock edge. Expected values come from a reference LFSR and from
// arithmetic on the number of rising edges an enable was held high.
// -----------------------------------------------------------------------------
module tb_reaction_timer;
   import reaction_pkg::*;

   localparam int CLK_HZ       = 4000;
   localparam int MIN_DELAY_MS = 2;
   localparam int RAND_BITS    = 2;
   localparam int TICK         = CLK_HZ / 1000;
   localparam int SAT          = 8191;

   logic        Clock = 1'b0;
   logic        CLRN = 1'b0;
   logic        delayCounterEnable = 1'b0;
   logic        scoreCounterEnable = 1'b0;
   logic        delayCounterDone;
   logic [12:0] scoreCounter;
   logic        scoreSaturated;

   int          checkCount = 0;
   int          passCount = 0;
   int          expScore = 0;
   logic [15:0] modelLfsr = 16'hACE1;

   always #5 Clock = ~Clock;

   reaction_timer #(
      .CLK_HZ       (CLK_HZ),
      .MIN_DELAY_MS (MIN_DELAY_MS),
      .RAND_BITS    (RAND_BITS)
   ) dut (
      .Clock              (Clock),
      .CLRN               (CLRN),
      .delayCounterEnable (delayCounterEnable),
      .scoreCounterEnable (scoreCounterEnable),
      .delayCounterDone   (delayCounterDone),
      .scoreCounter       (scoreCounter),
      .scoreSaturated     (scoreSaturated)
   );

   // Reference Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5), shifting toward bit 0.
   function automatic logic [15:0] lfsrStep(input logic [15:0] v);
      logic fb;
      fb = v[0] ^ v[2] ^ v[3] ^ v[5];
      return {fb, v[15:1]};
   endfunction

   always @(posedge Clock or negedge CLRN) begin
      if (!CLRN) modelLfsr <= 16'hACE1;
      else       modelLfsr <= lfsrStep(modelLfsr);
   end

   // Score after scoreCounterEnable was sampled high on edgesHigh rising edges,
   // first one being the start: one count per full ms after the start, capped.
   function automatic int scoreAfter(input int base, input int edgesHigh);
      int v;
      v = base + (edgesHigh - 1) / TICK;
      return (v > SAT) ? SAT : v;
   endfunction

   // Falling edges after raising delayCounterEnable until done is seen (-1 on timeout).
   task automatic measureDone(input int budget, output int latency);
      latency = -1;
      for (int k = 1; k <= budget; k++) begin
         @(negedge Clock);
         if (delayCounterDone === 1'b1) begin
            latency = k;
            break;
         end
      end
   endtask

   // Wait until the value the next edge samples has nonzero low bits (or exact value 3).
   task automatic waitLfsrLow(input bit wantThree);
      for (int g = 0; g < 64; g++) begin
         if (wantThree ? (modelLfsr[1:0] == 2'd3) : (modelLfsr[1:0] != 2'd0)) break;
         @(negedge Clock);
      end
      if (wantThree ? (modelLfsr[1:0] != 2'd3) : (modelLfsr[1:0] == 2'd0)) begin
         checkCount++;
         $display("FAIL lfsr_wait: wanted low bits never appeared within 64 clocks");
      end
   endtask

   task automatic test_reset();
      CLRN = 1'b0;
      delayCounterEnable = 1'b0;
      scoreCounterEnable = 1'b0;
      repeat (3) @(negedge Clock);
      checkCount++;
      if ({delayCounterDone, scoreSaturated, scoreCounter} !== 15'd0)
         $display("FAIL reset_outputs: done=%0b sat=%0b score=%0d, required all 0",
                  delayCounterDone, scoreSaturated, scoreCounter);
      else passCount++;
      checkCount++;
      if (dut.lfsrValue !== 16'hACE1)
         $display("FAIL reset_lfsr: got %h, required ace1", dut.lfsrValue);
      else passCount++;
      CLRN = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clock);
         checkCount++;
         if ({delayCounterDone, scoreSaturated, scoreCounter} !== 15'd0)
            $display("FAIL idle_outputs[%0d]: done=%0b sat=%0b score=%0d, required all 0",
                     i, delayCounterDone, scoreSaturated, scoreCounter);
         else passCount++;
         checkCount++;
         if (dut.lfsrValue !== modelLfsr || dut.lfsrValue == 16'h0000)
            $display("FAIL lfsr_sequence[%0d]: got %h, required %h (nonzero)",
                     i, dut.lfsrValue, modelLfsr);
         else passCount++;
      end
      expScore = 0;
   endtask

   task automatic test_delay_fixed();
      int latency;
      int expLatency;
      waitLfsrLow(1'b1);
      expLatency = TICK * (MIN_DELAY_MS + int'(modelLfsr[1:0])) + 1;
      delayCounterEnable = 1'b1;
      measureDone(60, latency);
      checkCount++;
      if (latency != expLatency)
         $display("FAIL delay_fixed_latency: done after %0d clocks, required %0d", latency, expLatency);
      else passCount++;
      expScore = 0;
      checkCount++;
      if (scoreCounter !== 13'(expScore))
         $display("FAIL delay_clears_score: got %0d, required %0d", scoreCounter, expScore);
      else passCount++;
      delayCounterEnable = 1'b0;
      repeat (10) @(negedge Clock);
      checkCount++;
      if (delayCounterDone !== 1'b1)
         $display("FAIL delay_done_held: got %0b after enable drop, required 1", delayCounterDone);
      else passCount++;
   endtask

   task automatic test_random_delays();
      int latency;
      int expLatency;
      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(0, 7)) @(negedge Clock);
         expLatency = TICK * (MIN_DELAY_MS + int'(modelLfsr[RAND_BITS-1:0])) + 1;
         delayCounterEnable = 1'b1;
         measureDone(60, latency);
         checkCount++;
         if (latency != expLatency)
            $display("FAIL delay_random_latency[%0d]: done after %0d clocks, required %0d",
                     r, latency, expLatency);
         else passCount++;
         delayCounterEnable = 1'b0;
         repeat ($urandom_range(1, 9)) @(negedge Clock);
         checkCount++;
         if (delayCounterDone !== 1'b1)
            $display("FAIL delay_random_hold[%0d]: got %0b, required 1", r, delayCounterDone);
         else passCount++;
      end
      expScore = 0;
   endtask

   task automatic test_score_fixed();
      scoreCounterEnable = 1'b1;
      repeat (41) @(negedge Clock);
      scoreCounterEnable = 1'b0;
      expScore = scoreAfter(expScore, 41);
      checkCount++;
      if (scoreCounter !== 13'(expScore))
         $display("FAIL score_fixed: got %0d, required %0d", scoreCounter, expScore);
      else passCount++;
      repeat (15) @(negedge Clock);
      checkCount++;
      if (scoreCounter !== 13'(expScore))
         $display("FAIL score_hold: got %0d, required %0d", scoreCounter, expScore);
      else passCount++;
   endtask

   task automatic test_random_score();
      int n;
      int base;
      int exp;
      for (int b = 0; b < 5; b++) begin
         n = $urandom_range(1, 30);
         base = expScore;
         exp = base;
         scoreCounterEnable = 1'b1;
         for (int i = 1; i <= n; i++) begin
            @(negedge Clock);
            exp = scoreAfter(base, i);
            checkCount++;
            if (scoreCounter !== 13'(exp))
               $display("FAIL score_burst[%0d] edge %0d: got %0d, required %0d",
                        b, i, scoreCounter, exp);
            else passCount++;
         end
         scoreCounterEnable = 1'b0;
         expScore = exp;
         repeat ($urandom_range(1, 6)) @(negedge Clock);
         checkCount++;
         if (scoreCounter !== 13'(expScore))
            $display("FAIL score_gap_hold[%0d]: got %0d, required %0d", b, scoreCounter, expScore);
         else passCount++;
      end
   endtask

   task automatic test_saturation();
      int exp;
      int lastEdge;
      delayCounterEnable = 1'b1;
      @(negedge Clock);
      delayCounterEnable = 1'b0;
      expScore = 0;
      checkCount++;
      if (scoreCounter !== 13'd0)
         $display("FAIL sat_pre_clear: got %0d, required 0", scoreCounter);
      else passCount++;
      lastEdge = TICK * 8200 + 1;
      scoreCounterEnable = 1'b1;
      for (int i = 1; i <= lastEdge; i++) begin
         @(negedge Clock);
         if (i == TICK * 8190 + 1 || i == TICK * 8191 + 1 || i == lastEdge) begin
            exp = scoreAfter(0, i);
            checkCount++;
            if (scoreCounter !== 13'(exp) || scoreSaturated !== (exp == SAT))
               $display("FAIL saturation edge %0d: score=%0d sat=%0b, required score=%0d sat=%0b",
                        i, scoreCounter, scoreSaturated, exp, (exp == SAT));
            else passCount++;
         end
      end
      expScore = SAT;
   endtask

   task automatic test_reset_midscore();
      @(negedge Clock);
      #2;
      CLRN = 1'b0;
      scoreCounterEnable = 1'b0;
      delayCounterEnable = 1'b0;
      #1;
      checkCount++;
      if ({delayCounterDone, scoreSaturated, scoreCounter} !== 15'd0)
         $display("FAIL reset_midscore_outputs: done=%0b sat=%0b score=%0d, required all 0",
                  delayCounterDone, scoreSaturated, scoreCounter);
      else passCount++;
      checkCount++;
      if (dut.lfsrValue !== 16'hACE1)
         $display("FAIL reset_midscore_lfsr: got %h, required ace1", dut.lfsrValue);
      else passCount++;
      repeat (2) @(negedge Clock);
      CLRN = 1'b1;
      expScore = 0;
   endtask

   task automatic test_both_enables();
      scoreCounterEnable = 1'b1;
      repeat (9) @(negedge Clock);
      scoreCounterEnable = 1'b0;
      expScore = scoreAfter(expScore, 9);
      checkCount++;
      if (scoreCounter !== 13'(expScore))
         $display("FAIL both_setup_score: got %0d, required %0d", scoreCounter, expScore);
      else passCount++;
      repeat (2) @(negedge Clock);
      waitLfsrLow(1'b0);
      delayCounterEnable = 1'b1;
      scoreCounterEnable = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge Clock);
         checkCount++;
         if (scoreCounter !== 13'd0)
            $display("FAIL both_clear_wins[%0d]: got %0d, required 0", i, scoreCounter);
         else passCount++;
      end
      checkCount++;
      if (dut.delayState !== D_COUNT)
         $display("FAIL both_midcount_state: got %0d, required %0d", dut.delayState, D_COUNT);
      else passCount++;
      delayCounterEnable = 1'b0;
      scoreCounterEnable = 1'b0;
      @(negedge Clock);
      checkCount++;
      if (delayCounterDone !== 1'b0 || dut.delayState !== D_IDLE)
         $display("FAIL abort: done=%0b state=%0d, required done=0 state=%0d",
                  delayCounterDone, dut.delayState, D_IDLE);
      else passCount++;
      repeat (30) @(negedge Clock);
      checkCount++;
      if (delayCounterDone !== 1'b0 || scoreCounter !== 13'd0)
         $display("FAIL abort_stays_idle: done=%0b score=%0d, required 0 and 0",
                  delayCounterDone, scoreCounter);
      else passCount++;
      expScore = 0;
   endtask

   task automatic test_reset_middelay();
      int latency;
      int expLatency;
      expLatency = TICK * (MIN_DELAY_MS + int'(modelLfsr[1:0])) + 1;
      delayCounterEnable = 1'b1;
      measureDone(60, latency);
      checkCount++;
      if (latency != expLatency)
         $display("FAIL pre_reset_latency: done after %0d clocks, required %0d", latency, expLatency);
      else passCount++;
      delayCounterEnable = 1'b0;
      repeat (3) @(negedge Clock);
      #2;
      CLRN = 1'b0;
      #1;
      checkCount++;
      if (delayCounterDone !== 1'b0 || dut.delayState !== D_IDLE)
         $display("FAIL reset_in_done: done=%0b state=%0d, required done=0 state=%0d",
                  delayCounterDone, dut.delayState, D_IDLE);
      else passCount++;
      repeat (2) @(negedge Clock);
      CLRN = 1'b1;
      @(negedge Clock);
      delayCounterEnable = 1'b1;
      repeat (6) @(negedge Clock);
      checkCount++;
      if (dut.delayState !== D_COUNT)
         $display("FAIL middelay_state: got %0d, required %0d", dut.delayState, D_COUNT);
      else passCount++;
      #2;
      CLRN = 1'b0;
      delayCounterEnable = 1'b0;
      #1;
      checkCount++;
      if ({delayCounterDone, scoreSaturated, scoreCounter} !== 15'd0 ||
          dut.delayState !== D_IDLE || dut.delayCount !== '0)
         $display("FAIL reset_middelay: done=%0b sat=%0b score=%0d state=%0d count=%0d, required all 0 / idle",
                  delayCounterDone, scoreSaturated, scoreCounter, dut.delayState, dut.delayCount);
      else passCount++;
      checkCount++;
      if (dut.lfsrValue !== 16'hACE1)
         $display("FAIL reset_middelay_lfsr: got %h, required ace1", dut.lfsrValue);
      else passCount++;
      repeat (2) @(negedge Clock);
      CLRN = 1'b1;
      repeat (40) @(negedge Clock);
      checkCount++;
      if (delayCounterDone !== 1'b0 || dut.delayState !== D_IDLE)
         $display("FAIL no_restart_after_reset: done=%0b state=%0d, required done=0 state=%0d",
                  delayCounterDone, dut.delayState, D_IDLE);
      else passCount++;
   endtask

   initial begin
      test_reset();
      test_delay_fixed();
      test_random_delays();
      test_score_fixed();
      test_random_score();
      test_saturation();
      test_reset_midscore();
      test_both_enables();
      test_reset_middelay();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d done", passCount, checkCount);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency; ms tick period = CLK_HZ/1000 clocks.
REQ-002 Parameter MIN_DELAY_MS, default 1000, fixed part of the random red-phase delay in ms.
REQ-003 Parameter RAND_BITS, default 11, width of the random delay addend, giving 0..2^RAND_BITS-1 ms.
REQ-004 Clock  input  1  single clock; all state on rising edge.
REQ-005 CLRN  input  1  reset; asynchronous, active-low.
REQ-006 delayCounterEnable  input  1  level high while the game is in the red/waiting phase.
REQ-007 scoreCounterEnable  input  1  level high while the game is in the green/measuring phase.
REQ-008 delayCounterDone  output  1  random delay expired; held until next delay load.
REQ-009 scoreCounter  output  13  elapsed reaction time in ms, unsigned.
REQ-010 scoreSaturated  output  1  scoreCounter has reached 8191.

Function
REQ-011 The block SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every clock, never holding zero.
REQ-012 Delay FSM states: D_IDLE, D_COUNT, D_DONE.
REQ-013 D_IDLE -> D_COUNT on rising edge of delayCounterEnable (low previous cycle, high now); same clock loads delay = MIN_DELAY_MS + LFSR[RAND_BITS-1:0] and clears the ms prescaler.
REQ-014 In D_COUNT the delay SHALL decrement by one per ms tick; on the tick making it 0, state -> D_DONE.
REQ-015 delayCounterDone SHALL be 1 exactly in D_DONE (registered output, no combinational path from inputs).
REQ-016 D_DONE -> D_COUNT on a new delayCounterEnable rising edge (reload); otherwise D_DONE holds, including after enable drops.
REQ-017 delayCounterEnable falling while in D_COUNT (abort) SHALL return to D_IDLE, done stays 0.
REQ-018 scoreCounter SHALL clear to 0 on any cycle delayCounterEnable is high; clear wins over increment if both enables are high.
REQ-019 Rising edge of scoreCounterEnable SHALL clear the ms prescaler so the first increment lands exactly CLK_HZ/1000 clocks later.
REQ-020 While scoreCounterEnable is high, scoreCounter SHALL increment by one per ms tick, saturating at 8191 (no wrap); scoreSaturated = (scoreCounter == 8191).
REQ-021 When scoreCounterEnable is low and delayCounterEnable is low, scoreCounter SHALL hold its value.
REQ-022 The prescaler SHALL count 0..CLK_HZ/1000-1 and wrap, producing a one-clock tick at the terminal count; it is shared by both counters.
REQ-023 Latency: input edges take effect on the first clock edge sampling them; outputs update one clock after the causing tick.

Reset
REQ-024 CLRN low SHALL asynchronously force: delay FSM D_IDLE, delay count 0, prescaler 0, scoreCounter 0, delayCounterDone 0, scoreSaturated 0, LFSR 16'hACE1, edge-detect registers 0.
REQ-025 Reset mid-count SHALL abandon the round; after release, a new enable rising edge is required to start a delay.

Structure
REQ-026 Constants (LFSR seed, tap positions, score max 8191, FSM state encodings) SHALL live in shared package reaction_pkg.
REQ-027 The LFSR SHALL be a separate sub-module lfsr16 (Clock, CLRN, 16-bit output).
REQ-028 Delay counter width SHALL be sized to hold MIN_DELAY_MS + 2^RAND_BITS - 1 (12 bits at defaults).

Verification (CLK_HZ=4000, MIN_DELAY_MS=2, RAND_BITS=2: 4-clock tick)
REQ-029 Release CLRN, hold inputs low 20 clocks -> all outputs 0, LFSR sequence starts ACE1 and never 0.
REQ-030 Raise delayCounterEnable with LFSR[1:0]=3 sampled -> delayCounterDone rises after exactly 5 ticks (20 clocks), stays 1 after enable drops.
REQ-031 Raise scoreCounterEnable for 40 clocks -> scoreCounter = 10, then holds 10 after enable drops.
REQ-032 Force scoreCounter near max (run 8200 ticks) -> stops at 8191, scoreSaturated = 1, no wrap.
REQ-033 Both enables high together for 8 clocks -> scoreCounter stays 0; drop delayCounterEnable mid-count -> FSM D_IDLE, done 0.
REQ-034 Assert CLRN low mid-D_COUNT and mid-score -> all outputs 0 immediately (asynchronously), LFSR = ACE1.
